modulo_alimentador_rolhas: RTL

//  Cork feeder: supply side of the cork path into the sealing machine's cork register.

---
 rtl/modulo_alimentador_rolhas.sv | 131 +++++++++++++
 1 files changed

// File: rtl/modulo_alimentador_rolhas.sv
// Cork feeder: keeps a local cork stock and delivers one batch of corks per
// low-level request over a valid/ready handshake, with a stock-shortage alarm.
module modulo_alimentador_rolhas #(
    parameter int W       = 7,
    parameter int EST_MAX = 99,
    parameter int CAP_MAQ = 99,
    parameter int LOTE    = 15
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         enable,
    input  logic         min_r,
    input  logic [W-1:0] nivel_maquina,
    input  logic         abastecer,
    input  logic [W-1:0] qtd_abastecer,
    input  logic         pronto,
    output logic         rolha_valida,
    output logic         lote_ativo,
    output logic [W-1:0] estoque,
    output logic [W-1:0] restante,
    output logic [7:0]   total_enviado,
    output logic         falta_estoque,
    output logic [1:0]   estado
);

    typedef enum logic [1:0] {
        OCIOSO      = 2'b00,
        CALCULA     = 2'b01,
        ENVIA       = 2'b10,
        SEM_ESTOQUE = 2'b11
    } estado_t;

    localparam logic [W:0]   EST_MAX_X = (W+1)'(EST_MAX);
    localparam logic [W-1:0] CAP_W     = W'(CAP_MAQ);
    localparam logic [W-1:0] LOTE_W    = W'(LOTE);
    localparam logic [W-1:0] UM_W      = W'(1);

    estado_t      estado_q, estado_d;
    logic [W-1:0] estoque_q, estoque_d;
    logic [W-1:0] restante_q, restante_d;
    logic [7:0]   total_q;
    logic [W:0]   soma;
    logic [W-1:0] lote_calc;
    logic         transfer;

    function automatic logic [W-1:0] sat_estoque(input logic [W:0] v);
        if (v > EST_MAX_X)
            return EST_MAX_X[W-1:0];
        else
            return v[W-1:0];
    endfunction

    // Batch size = min(LOTE, stock, free room in the machine), room clamped at 0.
    function automatic logic [W-1:0] tamanho_lote(input logic [W-1:0] est,
                                                  input logic [W-1:0] nivel);
        logic [W-1:0] folga;
        logic [W-1:0] m;
        folga = (nivel > CAP_W) ? '0 : CAP_W - nivel;
        m     = (est < LOTE_W) ? est : LOTE_W;
        return (folga < m) ? folga : m;
    endfunction

    assign rolha_valida = enable && (estado_q == ENVIA);
    assign transfer     = rolha_valida && pronto;
    assign lote_calc    = tamanho_lote(estoque_q, nivel_maquina);

    // While in ENVIA stock never falls below restante, so the decrement cannot underflow.
    assign soma = {1'b0, estoque_q}
                + (abastecer ? {1'b0, qtd_abastecer} : {(W+1){1'b0}})
                - {{W{1'b0}}, transfer};

    always_comb begin
        estado_d   = estado_q;
        restante_d = restante_q;
        estoque_d  = sat_estoque(soma);
        if (!enable) begin
            estado_d   = OCIOSO;
            restante_d = '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (min_r)
                        estado_d = (estoque_q == '0) ? SEM_ESTOQUE : CALCULA;
                end
                CALCULA: begin
                    restante_d = lote_calc;
                    estado_d   = (lote_calc == '0) ? OCIOSO : ENVIA;
                end
                ENVIA: begin
                    if (transfer) begin
                        restante_d = restante_q - UM_W;
                        if (restante_q == UM_W) begin
                            estado_d = OCIOSO;
                        end else if (estoque_d == '0) begin
                            estado_d   = SEM_ESTOQUE;
                            restante_d = '0;
                        end
                    end
                end
                SEM_ESTOQUE: begin
                    if (estoque_q != '0)
                        estado_d = OCIOSO;
                end
                default: estado_d = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            estado_q   <= OCIOSO;
            estoque_q  <= '0;
            restante_q <= '0;
            total_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            estoque_q  <= estoque_d;
            restante_q <= restante_d;
            if (transfer)
                total_q <= total_q + 8'd1;
        end
    end

    assign estado        = estado_q;
    assign lote_ativo    = (estado_q == ENVIA);
    assign falta_estoque = (estado_q == SEM_ESTOQUE);
    assign estoque       = estoque_q;
    assign restante      = restante_q;
    assign total_enviado = total_q;

endmodule
